serial_comparator: RTL and testbench
====================================

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter N, default 8, operand width in bits; the block SHALL support any N >= 2.
REQ-002 Port clk, input, 1, sole clock; all state SHALL update on the rising edge.
REQ-003 Port rst, input, 1, reset; reset SHALL be synchronous and active-high.
REQ-004 Port start, input, 1, request to compare the current a and b.
REQ-005 Port a, input, N, unsigned operand A; sampled only on the accept edge.
REQ-006 Port b, input, N, unsigned operand B; sampled only on the accept edge.
REQ-007 Port busy, output, 1, high while a comparison is in progress.
REQ-008 Port done, output, 1, one-cycle pulse marking a valid result.
REQ-009 Ports lesser, equal, greater, output, 1 each, registered result flags (A<B, A==B, A>B).

Function
REQ-010 The FSM SHALL have three states: IDLE, COMPARE and DONE.
REQ-011 Accept: in IDLE with start=1, the block SHALL on that edge capture a and b into internal shift registers, set bit index to N-1, clear lesser, equal and greater, set busy=1, and enter COMPARE.
REQ-012 start SHALL be ignored in COMPARE and DONE; a and b changes after the accept edge SHALL NOT affect the result.
REQ-013 COMPARE SHALL examine one bit pair per cycle, MSB first, at the current index.
REQ-014 If the bits differ, the block SHALL on that edge set greater=A-bit and lesser=~A-bit, set equal=0, set done=1 and busy=0, and enter DONE.
REQ-015 If the bits match and the index is 0, the block SHALL on that edge set equal=1, set done=1 and busy=0, and enter DONE.
REQ-016 If the bits match and the index is above 0, the block SHALL decrement the index and remain in COMPARE.
REQ-017 Latency: done SHALL rise m+1 edges after the accept edge, where m is the 0-based position of the first differing bit counted from the MSB; the equal case SHALL take N edges.
REQ-018 DONE SHALL last exactly one cycle, with done=1 and busy=0, then return to IDLE unconditionally; done SHALL be 0 in all other states.
REQ-019 At most one of lesser, equal and greater SHALL be 1 at any time; all three SHALL be 0 while busy=1.
REQ-020 The result flags SHALL hold their value after DONE until the next accept edge or reset.
REQ-021 start held high SHALL cause a new accept on the first IDLE cycle after DONE; the minimum period between accepts is therefore latency+2 cycles.

Reset
REQ-022 With rst=1 at an edge, the FSM SHALL go to IDLE, and busy, done, lesser, equal and greater SHALL all be 0; the shift registers and index SHALL be don't-care.
REQ-023 rst SHALL take priority over start and over any comparison in progress; a partial comparison SHALL be discarded and SHALL produce no done pulse.
REQ-024 The first accept after reset SHALL be possible on the first edge with rst=0.

Verification (N=8)
REQ-025 Accept a=0x80, b=0x7F -> next edge: done=1, greater=1, lesser=0, equal=0, busy=0 (latency 1).
REQ-026 Accept a=0x5A, b=0x5A -> busy=1 for 8 cycles, then done=1 with equal=1 on edge 8; flags still hold 3 cycles later with start=0.
REQ-027 Accept a=0x12, b=0x13 -> decision at bit 0, done on edge 8 with lesser=1; a and b driven to 0xFF in the middle of the comparison leave the result unchanged.
REQ-028 Accept a=0x00, b=0xFF, then assert rst on edge 1 -> no done pulse, all outputs 0, IDLE; the next accept of 0x01 vs 0x00 gives greater=1 on edge 8.
REQ-029 Pulse start repeatedly while busy=1 -> no re-accept and exactly one done per accepted request.
REQ-030 Hold start=1 with a=0x40, b=0x20 -> done with greater=1 on edge 2, DONE for one cycle, re-accept on the next IDLE cycle with flags cleared; check this over 10 random pairs against a reference compare.

Source files
------------

// File: rtl/serial_comparator.sv
// Bit-serial unsigned magnitude comparator: walks operand pairs MSB-first,
// one bit per clock, and stops at the first differing bit.
module serial_comparator #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         lesser,
    output logic         equal,
    output logic         greater
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t         state;
    logic [N-1:0]   sh_a;
    logic [N-1:0]   sh_b;
    logic [IW-1:0]  idx;
    logic           a_bit;
    logic           b_bit;

    // Operands shift left each step, so the bit under test is always the MSB.
    assign a_bit = sh_a[N-1];
    assign b_bit = sh_b[N-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            lesser  <= 1'b0;
            equal   <= 1'b0;
            greater <= 1'b0;
            // NOTE: sh_a, sh_b and idx are left out of reset on purpose; they are
            // always loaded on the accept edge before they are ever read.
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a    <= a;
                        sh_b    <= b;
                        idx     <= IW'(N - 1);
                        lesser  <= 1'b0;
                        equal   <= 1'b0;
                        greater <= 1'b0;
                        busy    <= 1'b1;
                        state   <= COMPARE;
                    end
                end

                COMPARE: begin
                    if (a_bit != b_bit) begin
                        greater <= a_bit;
                        lesser  <= ~a_bit;
                        equal   <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end else if (idx == '0) begin
                        equal   <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        idx     <= idx - 1'b1;
                        sh_a    <= sh_a << 1;
                        sh_b    <= sh_b << 1;
                    end
                end

                DONE: begin
                    // Result flags stay put here and in IDLE until the next accept.
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_comparator.sv
// Randomized scoreboard bench for serial_comparator: stimulus pushes expected
// flags and done-cycle, a negedge monitor pops and compares on each done pulse.
module tb_serial_comparator;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy;
    logic         done;
    logic         lesser;
    logic         equal;
    logic         greater;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic l;
        logic e;
        logic g;
        int   done_cyc;
    } exp_t;

    exp_t exp_q[$];

    serial_comparator #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .lesser  (lesser),
        .equal   (equal),
        .greater (greater)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference latency: first differing bit at position m from the MSB gives m+1
    // edges; identical operands take N edges.
    function automatic int lat_of(input logic [N-1:0] x, input logic [N-1:0] y);
        int diff;
        diff = int'(x ^ y);
        if (diff == 0) return N;
        return N + 1 - $clog2(diff + 1);
    endfunction

    task automatic push_exp(input logic [N-1:0] x, input logic [N-1:0] y, input int k);
        exp_t e;
        e.l = (x < y);
        e.e = (x == y);
        e.g = (x > y);
        e.done_cyc = k + lat_of(x, y);
        exp_q.push_back(e);
    endtask

    // Drive a request now (caller sits at a negedge) and return just after the accept edge.
    task automatic accept_now(input logic [N-1:0] x, input logic [N-1:0] y, input bit expect_done);
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (expect_done) push_exp(x, y, cyc);
        start = 1'b0;
    endtask

    task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y);
        @(negedge clk);
        accept_now(x, y, 1'b1);
        repeat (lat_of(x, y) + 1) @(posedge clk);
    endtask

    // Monitor: scoreboard compare on done, plus per-cycle flag invariants.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                check("flag_invariant",
                      {31'd0, ($countones({lesser, equal, greater}) <= 1)
                              && !(busy && (lesser || equal || greater))
                              && !(busy && done)}, 32'd1);
                if (done === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_flags", {29'd0, lesser, equal, greater}, {29'd0, e.l, e.e, e.g});
                        check("done_cycle", cyc, e.done_cyc);
                    end
                end else if (exp_q.size() > 0 && cyc > exp_q[0].done_cyc) begin
                    e = exp_q.pop_front();
                    check("missing_done", cyc, e.done_cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int lat;
        logic [N-1:0] na;
        logic [N-1:0] nb;

        // Reset state, then accept on the very first edge with rst low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {27'd0, busy, done, lesser, equal, greater}, 32'd0);
        rst = 1'b0;
        accept_now(8'h80, 8'h7F, 1'b1);
        check("first_edge_accept", {31'd0, busy}, 32'd1);
        repeat (lat_of(8'h80, 8'h7F) + 1) @(posedge clk);

        // Equal operands: busy for N cycles, flags held afterwards.
        @(negedge clk);
        accept_now(8'h5A, 8'h5A, 1'b1);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check("busy_during_equal", {31'd0, busy}, 32'd1);
        end
        repeat (4) @(negedge clk);
        check("equal_held", {28'd0, busy, done, lesser, equal, greater}, 32'b00010);

        // LSB decision with operands disturbed mid-comparison.
        @(negedge clk);
        accept_now(8'h12, 8'h13, 1'b1);
        repeat (3) @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        repeat (N + 1) @(posedge clk);

        // Reset during a comparison discards it without a done pulse.
        @(negedge clk);
        accept_now(8'h00, 8'hFF, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_abort_outputs", {27'd0, busy, done, lesser, equal, greater}, 32'd0);
        rst = 1'b0;
        accept_now(8'h01, 8'h00, 1'b1);
        repeat (lat_of(8'h01, 8'h00) + 1) @(posedge clk);

        // start pulsed while busy and in DONE is ignored.
        @(negedge clk);
        accept_now(8'h33, 8'h33, 1'b1);
        for (int i = 0; i < N + 1; i++) begin
            @(negedge clk);
            start = (i % 2 == 0);
            a = N'($urandom);
            b = N'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("no_reaccept", {31'd0, busy}, 32'd0);

        // Single-bit differences at random positions.
        for (int i = 0; i < 6; i++) begin
            na = N'($urandom);
            nb = na ^ N'(1 << $urandom_range(N - 1, 0));
            issue(na, nb);
        end

        // start held high: back-to-back accepts every latency+2 cycles.
        @(negedge clk);
        accept_now(8'h40, 8'h20, 1'b1);
        start = 1'b1;
        lat = lat_of(8'h40, 8'h20);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            na = N'($urandom);
            nb = (j % 3 == 0) ? na : N'($urandom);
            a = na;
            b = nb;
            repeat (lat + 2) @(posedge clk);
            #1;
            k = cyc;
            push_exp(na, nb, k);
            check("reaccept_cleared", {28'd0, busy, lesser, equal, greater}, 32'b1000);
            lat = lat_of(na, nb);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (lat + 2) @(posedge clk);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
